// File: rtl/compat_trig_sequencer_pkg.sv
// Shared definitions for the 40 MHz compatibility trigger sequencer.
// Holds the FSM state encoding, default datapath widths, requester bit
// indices and the ENABLE40 phase on which a slot closes.
package compat_trig_sequencer_pkg;

  localparam int unsigned COMPAT_N_TRIG       = 4;
  localparam int unsigned COMPAT_PRIO_BITS    = 2;
  localparam int unsigned COMPAT_HOLDOFF_BITS = 8;
  localparam int unsigned COMPAT_DROP_BITS    = 16;

  // Requester bit positions in TRIG_IN / TRIG_MASK (bit 0 = highest priority)
  localparam int unsigned TRIG_IDX_TOTD = 0;
  localparam int unsigned TRIG_IDX_TOT  = 1;
  localparam int unsigned TRIG_IDX_THR  = 2;
  localparam int unsigned TRIG_IDX_MOPS = 3;

  // Last phase of a 40 MHz slot; the slot's merged requests are issued here
  localparam logic [1:0] PHASE_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } seq_state_e;

endpackage

// File: rtl/compat_trig_sequencer_if.sv
// Trigger handshake between the compatibility sequencer and the shower buffer.
//   TRIG_VALID  sequencer -> buffer  trigger offered
//   TRIG_SRC    sequencer -> buffer  merged requester bits of the slot
//   TRIG_PRIO   sequencer -> buffer  index of lowest set bit of TRIG_SRC
//   TRIG_CLR    sequencer -> buffer  1-cycle pulse clearing ToTd windows
//   TRIG_ACK    buffer -> sequencer  trigger accepted
interface compat_trig_sequencer_if #(
  parameter int unsigned N_TRIG    = 4,
  parameter int unsigned PRIO_BITS = 2
);
  logic                 TRIG_VALID;
  logic [N_TRIG-1:0]    TRIG_SRC;
  logic [PRIO_BITS-1:0] TRIG_PRIO;
  logic                 TRIG_CLR;
  logic                 TRIG_ACK;

  modport master (
    output TRIG_VALID, TRIG_SRC, TRIG_PRIO, TRIG_CLR,
    input  TRIG_ACK
  );

  modport slave (
    input  TRIG_VALID, TRIG_SRC, TRIG_PRIO, TRIG_CLR,
    output TRIG_ACK
  );
endinterface

// File: rtl/compat_trig_sequencer_phase_gen.sv
// compat_phase_gen: 3-phase ENABLE40 strobe on CLK120.
//   CLK120    in   120 MHz clock
//   RESET_N   in   async reset, active low (phase returns to 0)
//   SYNC40    in   40 MHz reference pulse; forces next phase to 0
//   ENABLE40  out  current phase 0,1,2
module compat_phase_gen
  import compat_trig_sequencer_pkg::*;
(
  input  logic       CLK120,
  input  logic       RESET_N,
  input  logic       SYNC40,
  output logic [1:0] ENABLE40
);

  logic [1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + 2'd1;
    if (SYNC40 || phase_q == PHASE_LAST) phase_d = '0;
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) phase_q <= '0;
    else          phase_q <= phase_d;
  end

  assign ENABLE40 = phase_q;

endmodule

// File: rtl/compat_trig_sequencer.sv
// compat_trig_sequencer: merges compatibility trigger pulses into one 40 MHz
// slot, offers one trigger to the shower buffer by valid/ack, pulses the
// window clear and applies a post-issue holdoff counted in slot boundaries.
//   CLK120, RESET_N     clock, async active-low reset
//   SYNC40              40 MHz reference pulse (re-phases ENABLE40)
//   RUN                 enables request acceptance
//   TRIG_IN, TRIG_MASK  trigger pulses and per-requester enables
//   HOLDOFF             post-issue holdoff in 40 MHz ticks
//   DROP_CLR            clears DROP_COUNT
//   ENABLE40            current 40 MHz phase 0,1,2
//   BUSY                FSM not idle
//   DROP_COUNT          saturating count of requests lost in ISSUE/HOLDOFF
//   trig                handshake to the shower buffer (master side)
module compat_trig_sequencer
  import compat_trig_sequencer_pkg::*;
#(
  parameter int unsigned N_TRIG       = COMPAT_N_TRIG,
  parameter int unsigned PRIO_BITS    = COMPAT_PRIO_BITS,
  parameter int unsigned HOLDOFF_BITS = COMPAT_HOLDOFF_BITS,
  parameter int unsigned DROP_BITS    = COMPAT_DROP_BITS
) (
  input  logic                    CLK120,
  input  logic                    RESET_N,
  input  logic                    SYNC40,
  input  logic                    RUN,
  input  logic [N_TRIG-1:0]       TRIG_IN,
  input  logic [N_TRIG-1:0]       TRIG_MASK,
  input  logic [HOLDOFF_BITS-1:0] HOLDOFF,
  input  logic                    DROP_CLR,
  output logic [1:0]              ENABLE40,
  output logic                    BUSY,
  output logic [DROP_BITS-1:0]    DROP_COUNT,
  compat_trig_sequencer_if.master trig
);

  seq_state_e              state_q, state_d;
  logic [N_TRIG-1:0]       pend_q, pend_d;
  logic [HOLDOFF_BITS-1:0] hcnt_q, hcnt_d;
  logic [DROP_BITS-1:0]    drop_q, drop_d;
  logic                    clr_q, clr_d;

  logic [N_TRIG-1:0]       req;
  logic                    req_any;
  logic                    phase_last;
  logic                    issuing;
  logic [N_TRIG-1:0]       src;
  logic [PRIO_BITS-1:0]    prio;
  logic                    prio_found;

  compat_phase_gen u_phase (
    .CLK120   (CLK120),
    .RESET_N  (RESET_N),
    .SYNC40   (SYNC40),
    .ENABLE40 (ENABLE40)
  );

  assign req        = TRIG_IN & TRIG_MASK & {N_TRIG{RUN}};
  assign req_any    = |req;
  assign phase_last = (ENABLE40 == PHASE_LAST);
  assign issuing    = (state_q == ST_ISSUE);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    hcnt_d  = hcnt_q;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          pend_d  = req;
          state_d = phase_last ? ST_ISSUE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!RUN) begin
          pend_d  = '0;
          state_d = ST_IDLE;
        end else begin
          pend_d = pend_q | req;
          if (phase_last) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Requests arriving here are counted as drops, never merged
        if (trig.TRIG_ACK) begin
          clr_d  = 1'b1;
          pend_d = '0;
          if (HOLDOFF == '0) begin
            state_d = ST_IDLE;
          end else begin
            hcnt_d  = HOLDOFF;
            state_d = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        if (phase_last) begin
          if (hcnt_q <= HOLDOFF_BITS'(1)) begin
            hcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            hcnt_d = hcnt_q - HOLDOFF_BITS'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (DROP_CLR) begin
      drop_d = '0;
    end else if ((state_q == ST_ISSUE || state_q == ST_HOLDOFF) && req_any
                 && drop_q != '1) begin
      drop_d = drop_q + DROP_BITS'(1);
    end
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      hcnt_q  <= '0;
      drop_q  <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hcnt_q  <= hcnt_d;
      drop_q  <= drop_d;
      clr_q   <= clr_d;
    end
  end

  assign src = issuing ? pend_q : '0;

  // Lowest set bit wins; result is 0 when src is empty
  always_comb begin
    prio       = '0;
    prio_found = 1'b0;
    for (int unsigned i = 0; i < N_TRIG; i++) begin
      if (!prio_found && src[i]) begin
        prio       = PRIO_BITS'(i);
        prio_found = 1'b1;
      end
    end
  end

  assign trig.TRIG_VALID = issuing;
  assign trig.TRIG_SRC   = src;
  assign trig.TRIG_PRIO  = prio;
  assign trig.TRIG_CLR   = clr_q;
  assign BUSY            = (state_q != ST_IDLE);
  assign DROP_COUNT      = drop_q;

endmodule

// File: tb/tb_compat_trig_sequencer.sv
// Directed bench for compat_trig_sequencer. DROP_COUNT is narrowed to 4 bits
// so saturation is reachable in a few cycles.
module tb_compat_trig_sequencer;

  localparam int unsigned NT = 4;
  localparam int unsigned DB = 4;

  logic          CLK120 = 1'b0;
  logic          RESET_N = 1'b0;
  logic          SYNC40 = 1'b0;
  logic          RUN = 1'b0;
  logic [NT-1:0] TRIG_IN = '0;
  logic [NT-1:0] TRIG_MASK = '0;
  logic [7:0]    HOLDOFF = '0;
  logic          DROP_CLR = 1'b0;
  logic [1:0]    ENABLE40;
  logic          BUSY;
  logic [DB-1:0] DROP_COUNT;

  int checks = 0;
  int errors = 0;

  compat_trig_sequencer_if #(.N_TRIG(NT), .PRIO_BITS(2)) trig_if ();

  compat_trig_sequencer #(
    .N_TRIG       (NT),
    .PRIO_BITS    (2),
    .HOLDOFF_BITS (8),
    .DROP_BITS    (DB)
  ) dut (
    .CLK120     (CLK120),
    .RESET_N    (RESET_N),
    .SYNC40     (SYNC40),
    .RUN        (RUN),
    .TRIG_IN    (TRIG_IN),
    .TRIG_MASK  (TRIG_MASK),
    .HOLDOFF    (HOLDOFF),
    .DROP_CLR   (DROP_CLR),
    .ENABLE40   (ENABLE40),
    .BUSY       (BUSY),
    .DROP_COUNT (DROP_COUNT),
    .trig       (trig_if.master)
  );

  always #5 CLK120 = ~CLK120;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK120);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 4; i++) begin
      if (ENABLE40 == p) break;
      step();
    end
    check("wait_phase", 32'(ENABLE40), 32'(p));
  endtask

  initial begin
    trig_if.TRIG_ACK = 1'b0;

    // 1: reset state and free-running phase
    #23;
    check("rst_en40", 32'(ENABLE40), 0);
    check("rst_valid", 32'(trig_if.TRIG_VALID), 0);
    check("rst_src", 32'(trig_if.TRIG_SRC), 0);
    check("rst_clr", 32'(trig_if.TRIG_CLR), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_drop", 32'(DROP_COUNT), 0);
    @(negedge CLK120);
    RESET_N = 1'b1;
    step(); check("ph_a", 32'(ENABLE40), 1);
    step(); check("ph_b", 32'(ENABLE40), 2);
    step(); check("ph_c", 32'(ENABLE40), 0);
    step(); check("ph_d", 32'(ENABLE40), 1);
    SYNC40 = 1'b1;
    step(); check("sync_ph", 32'(ENABLE40), 0);
    SYNC40 = 1'b0;
    step(); check("sync_next", 32'(ENABLE40), 1);

    // 2: single request at phase 0, ack held
    RUN = 1'b1; TRIG_MASK = 4'b1111; HOLDOFF = 8'd0; trig_if.TRIG_ACK = 1'b1;
    wait_phase(0);
    TRIG_IN = 4'b0100;
    step(); TRIG_IN = '0;
    check("t2_v1", 32'(trig_if.TRIG_VALID), 0);
    check("t2_busy", 32'(BUSY), 1);
    step(); check("t2_v2", 32'(trig_if.TRIG_VALID), 0);
    step();
    check("t2_valid", 32'(trig_if.TRIG_VALID), 1);
    check("t2_src", 32'(trig_if.TRIG_SRC), 4'b0100);
    check("t2_prio", 32'(trig_if.TRIG_PRIO), 2);
    step();
    check("t2_vfall", 32'(trig_if.TRIG_VALID), 0);
    check("t2_clr", 32'(trig_if.TRIG_CLR), 1);
    check("t2_src0", 32'(trig_if.TRIG_SRC), 0);
    check("t2_idle", 32'(BUSY), 0);
    step(); check("t2_clr_end", 32'(trig_if.TRIG_CLR), 0);
    trig_if.TRIG_ACK = 1'b0;

    // 3: two requests merged into one slot; 4: ack withheld, drops counted
    wait_phase(0);
    TRIG_IN = 4'b0010;
    step(); TRIG_IN = '0;
    step(); check("t3_ph2", 32'(ENABLE40), 2);
    TRIG_IN = 4'b1000;
    step();
    check("t3_valid", 32'(trig_if.TRIG_VALID), 1);
    check("t3_src", 32'(trig_if.TRIG_SRC), 4'b1010);
    check("t3_prio", 32'(trig_if.TRIG_PRIO), 1);
    check("t4_drop0", 32'(DROP_COUNT), 0);
    TRIG_IN = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_valid", 32'(trig_if.TRIG_VALID), 1);
      check("t4_src", 32'(trig_if.TRIG_SRC), 4'b1010);
    end
    TRIG_IN = '0;
    check("t4_drop5", 32'(DROP_COUNT), 5);
    trig_if.TRIG_ACK = 1'b1;
    step();
    check("t4_vfall", 32'(trig_if.TRIG_VALID), 0);
    check("t4_clr", 32'(trig_if.TRIG_CLR), 1);
    trig_if.TRIG_ACK = 1'b0;

    // 5: holdoff of 3 slot boundaries, then holdoff 0
    HOLDOFF = 8'd3;
    wait_phase(2);
    TRIG_IN = 4'b0001; trig_if.TRIG_ACK = 1'b1;
    step(); TRIG_IN = '0;
    check("t5_valid", 32'(trig_if.TRIG_VALID), 1);
    check("t5_prio", 32'(trig_if.TRIG_PRIO), 0);
    step();
    check("t5_clr", 32'(trig_if.TRIG_CLR), 1);
    check("t5_hold", 32'(BUSY), 1);
    check("t5_vfall", 32'(trig_if.TRIG_VALID), 0);
    TRIG_IN = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      step();
      TRIG_IN = '0;
      check("t5_busy", 32'(BUSY), 1);
      check("t5_novalid", 32'(trig_if.TRIG_VALID), 0);
    end
    step();
    check("t5_idle", 32'(BUSY), 0);
    check("t5_drop6", 32'(DROP_COUNT), 6);
    HOLDOFF = 8'd0;
    TRIG_IN = 4'b0010;
    step(); TRIG_IN = '0;
    step(); step();
    check("t5_reissue", 32'(trig_if.TRIG_VALID), 1);
    check("t5_resrc", 32'(trig_if.TRIG_SRC), 4'b0010);
    step();
    check("t5_h0_idle", 32'(BUSY), 0);
    check("t5_h0_clr", 32'(trig_if.TRIG_CLR), 1);
    trig_if.TRIG_ACK = 1'b0;

    // 6: RUN low during COLLECT abandons the slot
    wait_phase(0);
    TRIG_IN = 4'b0100;
    step(); TRIG_IN = '0; RUN = 1'b0;
    step(); check("t6_abort", 32'(BUSY), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_novalid", 32'(trig_if.TRIG_VALID), 0);
    end
    RUN = 1'b1;
    // masked bit 0 ignored, stale pending must not reappear
    TRIG_MASK = 4'b1110;
    wait_phase(2);
    TRIG_IN = 4'b1001; trig_if.TRIG_ACK = 1'b1;
    step(); TRIG_IN = '0;
    check("t6_valid", 32'(trig_if.TRIG_VALID), 1);
    check("t6_src", 32'(trig_if.TRIG_SRC), 4'b1000);
    check("t6_prio", 32'(trig_if.TRIG_PRIO), 3);
    step();
    check("t6_idle", 32'(BUSY), 0);
    TRIG_MASK = 4'b1111;

    // SYNC40 during COLLECT re-phases but still issues only on phase 2
    wait_phase(0);
    TRIG_IN = 4'b0010;
    step(); TRIG_IN = '0; SYNC40 = 1'b1;
    step(); SYNC40 = 1'b0;
    check("sy_ph0", 32'(ENABLE40), 0);
    check("sy_wait", 32'(trig_if.TRIG_VALID), 0);
    step(); check("sy_w1", 32'(trig_if.TRIG_VALID), 0);
    step(); check("sy_w2", 32'(trig_if.TRIG_VALID), 0);
    step();
    check("sy_valid", 32'(trig_if.TRIG_VALID), 1);
    check("sy_src", 32'(trig_if.TRIG_SRC), 4'b0010);
    step();
    check("sy_idle", 32'(BUSY), 0);
    trig_if.TRIG_ACK = 1'b0;

    // drop counter saturation and DROP_CLR priority
    wait_phase(2);
    TRIG_IN = 4'b0100;
    step();
    check("sat_valid", 32'(trig_if.TRIG_VALID), 1);
    TRIG_IN = 4'b0001;
    for (int i = 0; i < 12; i++) step();
    check("sat_full", 32'(DROP_COUNT), 15);
    step();
    check("sat_hold", 32'(DROP_COUNT), 15);
    DROP_CLR = 1'b1;
    step();
    check("sat_clr", 32'(DROP_COUNT), 0);
    DROP_CLR = 1'b0;
    step();
    check("sat_inc", 32'(DROP_COUNT), 1);
    TRIG_IN = '0; trig_if.TRIG_ACK = 1'b1;
    step();
    check("sat_vfall", 32'(trig_if.TRIG_VALID), 0);
    check("sat_clrpulse", 32'(trig_if.TRIG_CLR), 1);
    trig_if.TRIG_ACK = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
